// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I main controller: Moore FSM sequencing the shared memory/ALU datapath
// through fetch, decode, execute and writeback, plus ALU and immediate decoders.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// FETCH    | read instr at PC, latch IR/OldPC, PC <= PC + 4
// DECODE   | read regs, precompute branch target OldPC + imm
// MEMADR   | ALUOut <= rs1 + imm (lw/sw address)
// MEMREAD  | read data memory at ALUOut
// MEMWB    | rd <= Data
// MEMWRITE | write rs2 to memory at ALUOut
// EXECUTER | ALUOut <= rs1 op rs2
// ALUWB    | rd <= ALUOut
// EXECUTEI | ALUOut <= rs1 op imm
// JAL      | ALUOut <= OldPC + 4, PC <= branch target
// BEQ      | compare rs1/rs2, PC <= target when taken
module multicycle_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               EN,
  input  logic [6:0]         OP,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic               Zero,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ImmSrc,
  output logic               RegWrite,
  output logic [2:0]         ALUControl,
  output logic               Illegal,
  output logic [STATE_W-1:0] STATE
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t     state;
  state_t     state_nxt;
  state_t     cur;
  logic       live;
  logic       op_legal;
  logic [1:0] alu_op;
  logic       pc_update;
  logic       branch;
  logic       ir_write_m;
  logic       mem_write_m;
  logic       reg_write_m;
  logic       unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // While reset is held the outputs present FETCH, whatever the register holds.
  assign cur  = RESET ? state : S_FETCH;
  assign live = EN & RESET;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state <= S_FETCH;
    end else if (EN) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    op_legal = 1'b0;
    case (OP)
      OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BR: op_legal = 1'b1;
      default:                                 op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (OP)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = S_EXECUTER;
          OP_I:         state_nxt = S_EXECUTEI;
          OP_JAL:       state_nxt = S_JAL;
          OP_BR:        state_nxt = S_BEQ;
          default:      state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR:   state_nxt = (OP == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_nxt = S_MEMWB;
      S_EXECUTER: state_nxt = S_ALUWB;
      S_EXECUTEI: state_nxt = S_ALUWB;
      S_JAL:      state_nxt = S_ALUWB;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWRITE: state_nxt = S_FETCH;
      S_ALUWB:    state_nxt = S_FETCH;
      S_BEQ:      state_nxt = S_FETCH;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // Moore outputs; write strobes are gated by EN/RESET below.
  always_comb begin
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    alu_op      = 2'b00;
    pc_update   = 1'b0;
    branch      = 1'b0;
    ir_write_m  = 1'b0;
    mem_write_m = 1'b0;
    reg_write_m = 1'b0;
    case (cur)
      S_FETCH: begin
        ir_write_m = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        pc_update  = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_m = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_m = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      S_ALUWB: begin
        reg_write_m = 1'b1;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
      end
      default: begin
        AdrSrc = 1'b0;
      end
    endcase
  end

  // funct3[0] selects bne (taken on not-zero) versus beq.
  assign PCWrite  = live & (pc_update | (branch & (Zero ^ funct3[0])));
  assign IRWrite  = live & ir_write_m;
  assign MemWrite = live & mem_write_m;
  assign RegWrite = live & reg_write_m;
  assign Illegal  = live & (cur == S_DECODE) & ~op_legal;
  assign STATE    = STATE_W'(cur);

  always_comb begin
    ImmSrc = 2'b00;
    case (OP)
      OP_SW:   ImmSrc = 2'b01;
      OP_BR:   ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    ALUControl = ALU_ADD;
    case (alu_op)
      2'b00: ALUControl = ALU_ADD;
      2'b01: ALUControl = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  ALUControl = (OP[5] & funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: an instruction-level model (state path per
// opcode, per-state control table) predicts every output each cycle under random EN/RESET.
module tb_multicycle_control_fsm;

  logic       CLK = 1'b0;
  logic       RESET, EN, Zero;
  logic [6:0] OP, funct7;
  logic [2:0] funct3;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] STATE;

  multicycle_control_fsm #(.STATE_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .OP(OP), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .ALUControl(ALUControl), .Illegal(Illegal),
    .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       ir, adr, mw, rw, pcu, br;
    logic [1:0] res, srca, srcb, aluop;
  } ctrl_t;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Instruction path as the sequence of visited states, straight from the latency rules.
  int path [0:4];
  int plen;
  int idx;

  task automatic build_path(input logic [6:0] op);
    path[0] = 0; path[1] = 1;
    case (op)
      7'b0000011: begin path[2] = 2; path[3] = 3; path[4] = 4; plen = 5; end
      7'b0100011: begin path[2] = 2; path[3] = 5; plen = 4; end
      7'b0110011: begin path[2] = 6; path[3] = 7; plen = 4; end
      7'b0010011: begin path[2] = 8; path[3] = 7; plen = 4; end
      7'b1101111: begin path[2] = 9; path[3] = 7; plen = 4; end
      7'b1100011: begin path[2] = 10; plen = 3; end
      default:    plen = 2;
    endcase
  endtask

  function automatic ctrl_t state_ctrl(input int s);
    ctrl_t c = '0;
    case (s)
      0:  begin c.ir = 1; c.srcb = 2; c.res = 2; c.pcu = 1; end
      1:  begin c.srca = 1; c.srcb = 1; end
      2:  begin c.srca = 2; c.srcb = 1; end
      3:  c.adr = 1;
      4:  begin c.res = 1; c.rw = 1; end
      5:  begin c.adr = 1; c.mw = 1; end
      6:  begin c.srca = 2; c.aluop = 2; end
      7:  c.rw = 1;
      8:  begin c.srca = 2; c.srcb = 1; c.aluop = 2; end
      9:  begin c.srca = 1; c.srcb = 2; c.pcu = 1; end
      10: begin c.srca = 2; c.aluop = 1; c.br = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] alu_ref(input logic [1:0] aluop, input logic [6:0] op,
                                         input logic [2:0] f3, input logic [6:0] f7);
    if (aluop == 2'd0) return 3'b000;
    if (aluop == 2'd1) return 3'b001;
    case (f3)
      3'b000:  return (op[5] && f7[5]) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] imm_ref(input logic [6:0] op);
    case (op)
      7'b0100011: return 2'b01;
      7'b1100011: return 2'b10;
      7'b1101111: return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  logic [6:0] legal_ops [0:5] = '{7'b0000011, 7'b0100011, 7'b0110011,
                                  7'b0010011, 7'b1101111, 7'b1100011};
  logic [6:0] dir_op [0:8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0110011,
                               7'b0110011, 7'b1100011, 7'b1100011, 7'b1111111, 7'b0000011};
  logic [2:0] dir_f3 [0:8] = '{3'd2, 3'd2, 3'd0, 3'd0, 3'd2, 3'd0, 3'd1, 3'd0, 3'd2};
  logic [6:0] dir_f7 [0:8] = '{7'h00, 7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

  int  dir_i = 0;
  bit  pick = 0;
  bit  random_phase = 0;

  task automatic next_instr();
    if (!random_phase && dir_i < 9) begin
      OP = dir_op[dir_i]; funct3 = dir_f3[dir_i]; funct7 = dir_f7[dir_i];
      dir_i++;
    end else begin
      random_phase = 1;
      if ($urandom_range(0, 4) == 0) OP = 7'($urandom);
      else OP = legal_ops[$urandom_range(0, 5)];
      funct3 = 3'($urandom);
      funct7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'($urandom);
    end
    build_path(OP);
  endtask

  task automatic do_cycle(input logic rst, input logic en);
    int    s;
    ctrl_t c;
    logic  live;
    @(negedge CLK);
    if (pick) begin
      next_instr();
      pick = 0;
    end
    RESET = rst;
    EN    = en;
    Zero  = 1'($urandom);
    #1;
    s    = rst ? path[idx] : 0;
    c    = state_ctrl(s);
    live = rst & en;
    chk("STATE",      16'(STATE),      16'(s));
    chk("IRWrite",    16'(IRWrite),    16'(live & c.ir));
    chk("MemWrite",   16'(MemWrite),   16'(live & c.mw));
    chk("RegWrite",   16'(RegWrite),   16'(live & c.rw));
    chk("PCWrite",    16'(PCWrite),    16'(live & (c.pcu | (c.br & (Zero ^ funct3[0])))));
    chk("AdrSrc",     16'(AdrSrc),     16'(c.adr));
    chk("ResultSrc",  16'(ResultSrc),  16'(c.res));
    chk("ALUSrcA",    16'(ALUSrcA),    16'(c.srca));
    chk("ALUSrcB",    16'(ALUSrcB),    16'(c.srcb));
    chk("ImmSrc",     16'(ImmSrc),     16'(imm_ref(OP)));
    chk("ALUControl", 16'(ALUControl), 16'(alu_ref(c.aluop, OP, funct3, funct7)));
    chk("Illegal",    16'(Illegal),    16'(live && s == 1 && plen == 2));
    @(posedge CLK);
    if (!rst) begin
      if (idx != 0) pick = 1;
      idx = 0;
    end else if (en) begin
      idx++;
      if (idx == plen) begin
        idx  = 0;
        pick = 1;
      end
    end
  endtask

  int stall_left = 3;
  bit aborted = 0;

  initial begin
    RESET = 0; EN = 1; Zero = 0;
    OP = dir_op[0]; funct3 = dir_f3[0]; funct7 = dir_f7[0];
    dir_i = 1;
    build_path(OP);
    idx = 0;
    repeat (2) do_cycle(1'b0, 1'b1);

    // Directed walk: lw, stalled sw, R-type variants, beq/bne, illegal, lw aborted in MEMREAD.
    for (int n = 0; n < 200 && !(dir_i == 9 && aborted && idx == 0 && pick == 0); n++) begin
      if (path[idx] == 5 && stall_left > 0) begin
        stall_left--;
        do_cycle(1'b1, 1'b0);
      end else if (dir_i == 9 && path[idx] == 3 && !aborted) begin
        aborted = 1;
        do_cycle(1'b0, 1'b1);
      end else begin
        do_cycle(1'b1, 1'b1);
      end
    end
    chk("directed_done", 16'(dir_i == 9 && aborted && stall_left == 0), 16'd1);

    random_phase = 1;
    for (int n = 0; n < 4000; n++) begin
      do_cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 4) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
